switch_input_pio: RTL and testbench

- Parametrised Avalon-MM input PIO for board switches/buttons; successor to the fixed 4-bit data-only switch port.
- Adds a per-bit synchroniser, counter-based debouncer, edge capture, an interrupt mask and a level IRQ.
- Sits between the top-level switch pins and the HPS/Nios interconnect as an Avalon-MM slave with a 2-bit word address.

---
 rtl/switch_input_pio.sv | 136 +++++++++++++
 tb/tb_switch_input_pio.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/switch_input_pio.sv
// rtl/switch_input_pio.sv - Avalon-MM switch input PIO with synchroniser, debouncer,
// edge capture and a masked level interrupt.
module switch_input_pio #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_MODE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int IW = $clog2(SYNC_STAGES + 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t           state;
   logic [IW-1:0]    init_cnt;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [CW-1:0]    db_cnt [WIDTH];

   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] ec_clr;
   logic             wr_en;
   logic [31:0]      read_word;
   logic             unused_wd;

   assign sync      = sync_q[SYNC_STAGES-1];
   assign wr_en     = chipselect && !write_n;
   assign unused_wd = &{1'b0, writedata};

   always_comb begin
      accept   = '0;
      edge_set = '0;
      ec_clr   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         accept[i] = (state == RUN) && (sync[i] != stable[i]) &&
                     (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
      end
      // sync carries the level being accepted, so it tells the edge direction
      case (EDGE_MODE)
         0:       edge_set = accept & sync;
         1:       edge_set = accept & ~sync;
         default: edge_set = accept;
      endcase
      if (wr_en && address == 2'd3) begin
         ec_clr = writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      read_word = '0;
      case (address)
         2'd0:    read_word[WIDTH-1:0] = stable;
         2'd1:    read_word[WIDTH-1:0] = sync;
         2'd2:    read_word[WIDTH-1:0] = irqmask;
         default: read_word[WIDTH-1:0] = edgecapture;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= INIT;
         init_cnt <= '0;
         stable   <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         case (state)
            INIT: begin
               // wait for the synchroniser to fill, then adopt its level silently
               if (init_cnt == IW'(SYNC_STAGES)) begin
                  stable <= sync;
                  state  <= RUN;
               end else begin
                  init_cnt <= init_cnt + IW'(1);
               end
            end
            default: begin
               stable <= (stable & ~accept) | (sync & accept);
               for (int i = 0; i < WIDTH; i++) begin
                  if (sync[i] == stable[i] || accept[i]) begin
                     db_cnt[i] <= '0;
                  end else begin
                     db_cnt[i] <= db_cnt[i] + CW'(1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask     <= '0;
         edgecapture <= '0;
         readdata    <= '0;
      end else begin
         if (wr_en && address == 2'd2) begin
            irqmask <= writedata[WIDTH-1:0];
         end
         edgecapture <= (edgecapture & ~ec_clr) | edge_set;
         readdata    <= read_word;
      end
   end

   assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_switch_input_pio.sv
// tb/tb_switch_input_pio.sv - directed bench for switch_input_pio.
module tb_switch_input_pio;

   logic        clk = 1'b0;
   logic        rst_n, rst_c_n;
   logic [1:0]  address;
   logic        write_n;
   logic [31:0] writedata;
   logic        cs_a, cs_b, cs_c;
   logic [3:0]  in_a, in_b;
   logic [31:0] in_c;
   logic [31:0] rd_a, rd_b, rd_c;
   logic        irq_a, irq_b, irq_c;
   logic [31:0] v;
   int          vec = 0;
   int          errs = 0;

   always #5 clk = ~clk;

   switch_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) dut_a (
      .clk(clk), .reset_n(rst_n), .address(address), .chipselect(cs_a), .write_n(write_n),
      .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));

   switch_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) dut_b (
      .clk(clk), .reset_n(rst_n), .address(address), .chipselect(cs_b), .write_n(write_n),
      .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));

   switch_input_pio #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) dut_c (
      .clk(clk), .reset_n(rst_c_n), .address(address), .chipselect(cs_c), .write_n(write_n),
      .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int d, input logic [1:0] a, input logic [31:0] data);
      @(negedge clk);
      address = a; writedata = data; write_n = 1'b0;
      cs_a = (d == 0); cs_b = (d == 1); cs_c = (d == 2);
      @(negedge clk);
      write_n = 1'b1; cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
   endtask

   task automatic rd(input int d, input logic [1:0] a, output logic [31:0] data);
      @(negedge clk);
      address = a;
      @(negedge clk);
      data = (d == 0) ? rd_a : (d == 1) ? rd_b : rd_c;
   endtask

   initial begin
      rst_n = 1'b0; rst_c_n = 1'b0;
      address = 2'd0; write_n = 1'b1; writedata = '0;
      cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
      in_a = 4'b1010; in_b = 4'b0000; in_c = '0;
      repeat (3) @(negedge clk);
      chk("reset_readdata", rd_a, 32'h0);
      chk("reset_irq", {31'h0, irq_a}, 32'h0);
      rst_n = 1'b1; rst_c_n = 1'b1;
      repeat (8) @(negedge clk);

      // power-up level adopted without an edge
      rd(0, 2'd0, v); chk("powerup_data", v, 32'h0000000A);
      rd(0, 2'd3, v); chk("powerup_edge", v, 32'h0);
      chk("powerup_irq", {31'h0, irq_a}, 32'h0);

      in_a = 4'b0000;
      repeat (10) @(negedge clk);
      wr(0, 2'd2, 32'h1);
      rd(0, 2'd0, v); chk("fall_data", v, 32'h0);
      rd(0, 2'd3, v); chk("fall_no_edge", v, 32'h0);

      // rising edge on bit 0: exact latency 2 sync + 4 debounce + 1 read
      @(negedge clk);
      address = 2'd0; in_a = 4'b0001;
      repeat (5) @(negedge clk);
      chk("rise_irq_early", {31'h0, irq_a}, 32'h0);
      @(negedge clk);
      chk("rise_irq", {31'h0, irq_a}, 32'h1);
      chk("rise_data_early", rd_a, 32'h0);
      @(negedge clk);
      chk("rise_data", rd_a, 32'h1);
      repeat (3) @(negedge clk);
      rd(0, 2'd3, v); chk("rise_edge", v, 32'h1);
      wr(0, 2'd3, 32'h1);
      chk("clear_irq", {31'h0, irq_a}, 32'h0);
      rd(0, 2'd3, v); chk("clear_edge", v, 32'h0);

      // 3-cycle glitch on bit 2 visible on RAW only
      @(negedge clk);
      address = 2'd1; in_a = 4'b0101;
      repeat (3) @(negedge clk);
      chk("glitch_raw_hi", rd_a, 32'h5);
      in_a = 4'b0001;
      repeat (3) @(negedge clk);
      chk("glitch_raw_lo", rd_a, 32'h1);
      repeat (6) @(negedge clk);
      rd(0, 2'd0, v); chk("glitch_data", v, 32'h1);
      rd(0, 2'd3, v); chk("glitch_edge", v, 32'h0);

      // masking
      wr(0, 2'd2, 32'h0);
      in_a = 4'b0000;
      repeat (10) @(negedge clk);
      in_a = 4'b0011;
      repeat (10) @(negedge clk);
      rd(0, 2'd3, v); chk("mask_edge", v, 32'h3);
      chk("mask_irq_off", {31'h0, irq_a}, 32'h0);
      wr(0, 2'd2, 32'h2);
      chk("mask_irq_on", {31'h0, irq_a}, 32'h1);
      rd(0, 2'd2, v); chk("mask_read", v, 32'h2);
      wr(0, 2'd0, 32'hFFFFFFFF);
      rd(0, 2'd0, v); chk("data_ro", v, 32'h3);

      // any-edge mode: clear coinciding with falling capture, set wins
      @(negedge clk);
      address = 2'd3; in_b = 4'b1000;
      repeat (7) @(negedge clk);
      chk("any_rise_edge", rd_b, 32'h8);
      @(negedge clk);
      in_b = 4'b0000;
      repeat (5) @(negedge clk);
      writedata = 32'h8; write_n = 1'b0; cs_b = 1'b1;
      @(negedge clk);
      write_n = 1'b1; cs_b = 1'b0;
      rd(1, 2'd3, v); chk("set_wins", v, 32'h8);
      rd(1, 2'd0, v); chk("any_data", v, 32'h0);

      // 32-bit instance: asynchronous reset mid-debounce
      wr(2, 2'd2, 32'hFFFFFFFF);
      in_c = 32'h000000FF;
      repeat (10) @(negedge clk);
      rd(2, 2'd3, v); chk("w32_edge", v, 32'h000000FF);
      chk("w32_irq", {31'h0, irq_c}, 32'h1);
      in_c = 32'hFFFFFFFF;
      repeat (3) @(negedge clk);
      rst_c_n = 1'b0;
      #1;
      chk("async_irq", {31'h0, irq_c}, 32'h0);
      chk("async_readdata", rd_c, 32'h0);
      repeat (2) @(negedge clk);
      rst_c_n = 1'b1;
      repeat (10) @(negedge clk);
      rd(2, 2'd3, v); chk("post_reset_edge", v, 32'h0);
      rd(2, 2'd0, v); chk("post_reset_data", v, 32'hFFFFFFFF);
      rd(2, 2'd2, v); chk("post_reset_mask", v, 32'h0);
      wr(2, 2'd2, 32'hFFFFFFFF);
      chk("post_reset_irq", {31'h0, irq_c}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
